// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Pointer width rule: ADDR_W+1 bits, so full and empty can be told apart.
package fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int ptr_w(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read address.
// The array is named memArray so benches can reach it as mem.memArray.
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = clog2(DEF_DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] memArray [DEPTH];

    always_ff @(posedge clk) begin
        if (we) memArray[waddr] <= wdata;
    end

    assign rdata = memArray[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with count, almost flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wen,
    input  logic [WIDTH-1:0]          w_word,
    input  logic                      ren,
    output logic [WIDTH-1:0]          r_word,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [ptr_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int PTR_W  = ptr_w(DEPTH);
    localparam logic [PTR_W-1:0] AF_L = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_L = PTR_W'(AE_THRESH);

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [WIDTH-1:0] head;
    logic             w_acc;
    logic             r_acc;

    // Status is decoded from registered pointers only.
    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                   (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign count        = wptr - rptr;
    assign almost_full  = (count >= AF_L);
    assign almost_empty = (count <= AE_L);

    assign w_acc = wen && !full;
    assign r_acc = ren && !empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_acc) wptr <= wptr + PTR_W'(1);
            if (r_acc) rptr <= rptr + PTR_W'(1);
            overflow  <= wen && full;
            underflow <= ren && empty;
        end
    end

    sync_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) mem (
        .clk   (clk),
        .we    (rst && w_acc),
        .waddr (wptr[ADDR_W-1:0]),
        .wdata (w_word),
        .raddr (rptr[ADDR_W-1:0]),
        .rdata (head)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign r_word = head;
`else
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_word <= '0;
        end else if (r_acc) begin
            r_word <= head;
        end
    end
`endif

endmodule
